// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit with a variable-latency memory handshake, wait timeout and sticky fault state.
// Optional perf counters (cyc_cnt, ret_cnt) are built when MC_PERF_CNT_EN is defined.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 4,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUSrcA,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUSel,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic [1:0]         fault
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   ret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_FAULT  = 4'd12
  } state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] fault_q, fault_d;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Memory-state wait: mem_ready wins even in the last allowed cycle; otherwise count or time out.
  function automatic logic mem_timed_out(input logic ready, input logic [7:0] cnt);
    return !ready && (cnt == WAIT_LAST);
  endfunction

  // NOTE: every output and next-state term gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    PCSource   = 2'b00;
    ALUSrcB    = 2'b00;
    ALUSel     = ALU_AND;
    instr_done = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUSel  = ALU_ADD;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (mem_timed_out(mem_ready, wait_q)) begin
          state_d = S_FAULT;
          fault_d = FLT_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUSel  = ALU_ADD;
        case (opcode)
          6'h00:        state_d = S_EXEC;
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h08:        state_d = S_ADDIEX;
          6'h02:        state_d = S_JUMP;
          default: begin
            state_d = S_FAULT;
            fault_d = FLT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUSel  = ALU_ADD;
        state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD, S_MEMWR: begin
        IorD     = 1'b1;
        MemRead  = (state_q == S_MEMRD);
        MemWrite = (state_q == S_MEMWR);
        if (mem_ready) begin
          instr_done = (state_q == S_MEMWR);
          state_d    = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (mem_timed_out(mem_ready, wait_q)) begin
          state_d = S_FAULT;
          fault_d = FLT_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSel  = ALU_ADD;
        state_d = S_ALUWB;
        case (func)
          6'h20: ALUSel = ALU_ADD;
          6'h22: ALUSel = ALU_SUB;
          6'h24: ALUSel = ALU_AND;
          6'h25: ALUSel = ALU_OR;
          6'h2A: ALUSel = ALU_SLT;
          default: begin
            state_d = S_FAULT;
            fault_d = FLT_ILLEGAL;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSel     = ALU_SUB;
        PCSource   = 2'b01;
        PCEn       = opcode[0] ? ~zero : zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUSel  = ALU_ADD;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCEn       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FAULT;
    endcase

    // Any state change restarts the wait count, which covers entry into FETCH/MEMRD/MEMWR.
    if (state_d != state_q) wait_d = '0;

    // Reset is asynchronous; FETCH must not drive MemRead while the datapath is still in reset.
    if (!rst) begin
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      ALUSrcA    = 1'b0;
      PCSource   = 2'b00;
      ALUSrcB    = 2'b00;
      ALUSel     = ALU_AND;
      instr_done = 1'b0;
    end
  end

  assign state = STATE_W'(state_q);
  assign fault = fault_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_FAULT) cyc_q <= cyc_q + 1'b1;
      if (instr_done)         ret_q <= ret_q + 1'b1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues hand-computed per-cycle expectations, a monitor compares.
// Define MC_PERF_CNT_EN to also check the perf counters.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, func;
  logic        zero, mem_ready;
  logic        PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  PCSource, ALUSrcB;
  logic [2:0]  ALUSel;
  logic [3:0]  state;
  logic        instr_done;
  logic [1:0]  fault;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(15), .STATE_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUSel(ALUSel), .state(state),
    .instr_done(instr_done), .fault(fault)
`ifdef MC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // Control word: {PCEn,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,PCSource,ALUSrcB,ALUSel}
  localparam logic [15:0] C_OFF       = 16'h0000;
  localparam logic [15:0] C_FETCH     = 16'h200A;
  localparam logic [15:0] C_FETCH_RDY = 16'hA40A;
  localparam logic [15:0] C_DEC       = 16'h001A;
  localparam logic [15:0] C_MEMADR    = 16'h0092;
  localparam logic [15:0] C_MEMRD     = 16'h6000;
  localparam logic [15:0] C_MEMWB     = 16'h0A00;
  localparam logic [15:0] C_MEMWR     = 16'h5000;
  localparam logic [15:0] C_EXEC_ADD  = 16'h0082;
  localparam logic [15:0] C_EXEC_SUB  = 16'h0086;
  localparam logic [15:0] C_EXEC_SLT  = 16'h0087;
  localparam logic [15:0] C_ALUWB     = 16'h0300;
  localparam logic [15:0] C_BR_TAKEN  = 16'h80A6;
  localparam logic [15:0] C_BR_NOT    = 16'h00A6;
  localparam logic [15:0] C_ADDIEX    = 16'h0092;
  localparam logic [15:0] C_ADDIWB    = 16'h0200;
  localparam logic [15:0] C_JUMP      = 16'h8040;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        done;
    logic [1:0]  flt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_idx = 0;

  wire [15:0] act_ctrl = {PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst,
                          ALUSrcA, PCSource, ALUSrcB, ALUSel};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check($sformatf("cyc%0d state", cyc_idx), 32'(state), 32'(mon_e.st));
      check($sformatf("cyc%0d ctrl", cyc_idx), 32'(act_ctrl), 32'(mon_e.ctrl));
      check($sformatf("cyc%0d instr_done", cyc_idx), 32'(instr_done), 32'(mon_e.done));
      check($sformatf("cyc%0d fault", cyc_idx), 32'(fault), 32'(mon_e.flt));
      cyc_idx++;
    end
  end

  // Drive inputs for n cycles and queue what each of those cycles must show.
  task automatic step(input int n, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [3:0] st,
                      input logic [15:0] ctrl, input logic dn, input logic [1:0] fl);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst = r; opcode = op; func = fn; zero = z; mem_ready = mr;
      e.st = st; e.ctrl = ctrl; e.done = dn; e.flt = fl;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  // FETCH accepted immediately, then DECODE with mem_ready held high (must be ignored there).
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input logic z);
    step(1, 1'b1, op, fn, z, 1'b1, 4'd0, C_FETCH_RDY, 1'b0, 2'b00);
    step(1, 1'b1, op, fn, z, 1'b1, 4'd1, C_DEC, 1'b0, 2'b00);
  endtask

  task automatic do_add();
    fetch_decode(6'h00, 6'h20, 1'b0);
    step(1, 1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 4'd6, C_EXEC_ADD, 1'b0, 2'b00);
    step(1, 1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 4'd7, C_ALUWB, 1'b1, 2'b00);
  endtask

  task automatic do_reset();
    step(1, 1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd0, C_OFF, 1'b0, 2'b00);
  endtask

  initial begin
    rst = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset: FETCH state with mem_ready high, yet all controls must stay low.
    step(2, 1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd0, C_OFF, 1'b0, 2'b00);

    for (int k = 0; k < 3; k++) do_add();
`ifdef MC_PERF_CNT_EN
    check("perf ret_cnt after 3 adds", ret_cnt, 32'd3);
    check("perf cyc_cnt after 3 adds", cyc_cnt, 32'd12);
`endif

    // lw with 3-cycle delays in FETCH and MEMRD: 11 cycles.
    step(3, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd0, C_FETCH, 1'b0, 2'b00);
    step(1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, 1'b0, 2'b00);
    step(1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd1, C_DEC, 1'b0, 2'b00);
    step(1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd2, C_MEMADR, 1'b0, 2'b00);
    step(3, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd3, C_MEMRD, 1'b0, 2'b00);
    step(1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 4'd3, C_MEMRD, 1'b0, 2'b00);
    step(1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd4, C_MEMWB, 1'b1, 2'b00);

    // Branches: beq/bne with zero=1 and zero=0.
    fetch_decode(6'h04, 6'h00, 1'b1);
    step(1, 1'b1, 6'h04, 6'h00, 1'b1, 1'b1, 4'd8, C_BR_TAKEN, 1'b1, 2'b00);
    fetch_decode(6'h05, 6'h00, 1'b1);
    step(1, 1'b1, 6'h05, 6'h00, 1'b1, 1'b1, 4'd8, C_BR_NOT, 1'b1, 2'b00);
    fetch_decode(6'h05, 6'h00, 1'b0);
    step(1, 1'b1, 6'h05, 6'h00, 1'b0, 1'b1, 4'd8, C_BR_TAKEN, 1'b1, 2'b00);
    fetch_decode(6'h04, 6'h00, 1'b0);
    step(1, 1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 4'd8, C_BR_NOT, 1'b1, 2'b00);

    // addi and j.
    fetch_decode(6'h08, 6'h00, 1'b0);
    step(1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 4'd9, C_ADDIEX, 1'b0, 2'b00);
    step(1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 4'd10, C_ADDIWB, 1'b1, 2'b00);
    fetch_decode(6'h02, 6'h00, 1'b0);
    step(1, 1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 4'd11, C_JUMP, 1'b1, 2'b00);

    // R-type sub and slt.
    fetch_decode(6'h00, 6'h22, 1'b0);
    step(1, 1'b1, 6'h00, 6'h22, 1'b0, 1'b1, 4'd6, C_EXEC_SUB, 1'b0, 2'b00);
    step(1, 1'b1, 6'h00, 6'h22, 1'b0, 1'b1, 4'd7, C_ALUWB, 1'b1, 2'b00);
    fetch_decode(6'h00, 6'h2A, 1'b0);
    step(1, 1'b1, 6'h00, 6'h2A, 1'b0, 1'b1, 4'd6, C_EXEC_SLT, 1'b0, 2'b00);
    step(1, 1'b1, 6'h00, 6'h2A, 1'b0, 1'b1, 4'd7, C_ALUWB, 1'b1, 2'b00);

    // sw with a 2-cycle write delay.
    fetch_decode(6'h2B, 6'h00, 1'b0);
    step(1, 1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd2, C_MEMADR, 1'b0, 2'b00);
    step(2, 1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, C_MEMWR, 1'b0, 2'b00);
    step(1, 1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd5, C_MEMWR, 1'b1, 2'b00);

    // Timeout boundary: mem_ready in the 15th FETCH cycle (count = 14) is still accepted.
    step(14, 1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 4'd0, C_FETCH, 1'b0, 2'b00);
    step(1, 1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, 1'b0, 2'b00);
    step(1, 1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 4'd1, C_DEC, 1'b0, 2'b00);
    step(1, 1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 4'd11, C_JUMP, 1'b1, 2'b00);

    // Reset in the middle of MEMRD, then a normal add.
    fetch_decode(6'h23, 6'h00, 1'b0);
    step(1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd2, C_MEMADR, 1'b0, 2'b00);
    step(1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd3, C_MEMRD, 1'b0, 2'b00);
    do_reset();
    do_add();

    // sw with mem_ready stuck low: 15 MemWrite cycles, then timeout fault; later mem_ready ignored.
    fetch_decode(6'h2B, 6'h00, 1'b0);
    step(1, 1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd2, C_MEMADR, 1'b0, 2'b00);
    step(15, 1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, C_MEMWR, 1'b0, 2'b00);
    step(3, 1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd12, C_OFF, 1'b0, 2'b10);
    step(1, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 4'd12, C_OFF, 1'b0, 2'b10);
    do_reset();

    // Illegal opcode 3F: DECODE -> FAULT with code 01, sticky through mem_ready pulses.
    fetch_decode(6'h3F, 6'h00, 1'b0);
    step(2, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 4'd12, C_OFF, 1'b0, 2'b01);
    step(1, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 4'd12, C_OFF, 1'b0, 2'b01);
    step(1, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 4'd12, C_OFF, 1'b0, 2'b01);
    do_reset();

    // Illegal funct: EXEC -> FAULT, no ALUWB write-back.
    fetch_decode(6'h00, 6'h3F, 1'b0);
    step(1, 1'b1, 6'h00, 6'h3F, 1'b0, 1'b1, 4'd6, C_EXEC_ADD, 1'b0, 2'b00);
    step(2, 1'b1, 6'h00, 6'h3F, 1'b0, 1'b1, 4'd12, C_OFF, 1'b0, 2'b01);
    do_reset();
    do_add();

    @(negedge clk);
    check("scoreboard drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
